// File: rtl/aes_128_inv.sv
// aes_128_inv: multicycle AES-128 inverse cipher; forward key expansion, then on-the-fly inverse key schedule
// Ports: clk, rst (async, active-high), start, in_bus[127:0] ciphertext, key[127:0] cipher key,
//        out_bus[127:0] registered plaintext, ready (IDLE/DONE), valid (DONE).
// Optional: AES_128_INV_KEY_CACHE_EN keeps the last expanded round key 10 to skip EXPAND on a repeated key.
module aes_128_inv (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  output logic [127:0] out_bus,
  output logic         ready,
  output logic         valid
);
  typedef enum logic [2:0] {IDLE, EXPAND, RND_A, RND_B, DONE} state_t;
  state_t r_fsm, w_nxt;
  logic [127:0] r_state, r_key, w_ks, w_iks, w_isb, w_imc, w_rk10;
  logic [3:0] r_rnd;
  logic w_acc, w_hit;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return i < 4'd8 ? 8'h01 << i : (i == 4'd8 ? 8'h1b : 8'h36);
  endfunction
  function automatic logic [127:0] key_schedule(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = n0 ^ k[95:64];
    n2 = n1 ^ k[63:32];
    return {n0, n1, n2, n2 ^ k[31:0]};
  endfunction
  function automatic logic [127:0] inv_ks(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p3;
    p3 = k[31:0] ^ k[63:32];
    return {k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0}, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], p3};
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction
  assign ready = r_fsm == IDLE || r_fsm == DONE;
  assign valid = r_fsm == DONE;
  assign w_acc = start && ready;
  assign w_ks  = key_schedule(r_key, rcon(r_rnd));
  assign w_iks = inv_ks(r_key, rcon(r_rnd - 4'd1));
  // Round key 10 is added only on the first A cycle; later round keys are added ahead of InvMixColumns in B,
  // and round key 0 is added when the final plaintext is written.
  assign w_isb = inv_sub_bytes(inv_shift_rows(r_state ^ (r_rnd == 4'd10 ? r_key : '0)));
  assign w_imc = inv_mix_columns(r_state ^ r_key);
`ifdef AES_128_INV_KEY_CACHE_EN
  logic [127:0] r_rk10, r_tag;
  logic r_tag_vld;
  assign w_hit  = r_tag_vld && key == r_tag;
  assign w_rk10 = r_rk10;
  // The tag is written at accept but only marked valid once EXPAND completes, so an aborted expansion never hits.
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_tag_vld <= 1'b0;
    else if (w_acc && !w_hit) begin
      r_tag     <= key;
      r_tag_vld <= 1'b0;
    end else if (r_fsm == EXPAND && r_rnd == 4'd9) begin
      r_rk10    <= w_ks;
      r_tag_vld <= 1'b1;
    end
`else
  assign w_hit  = 1'b0;
  assign w_rk10 = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_fsm <= IDLE;
    else
      r_fsm <= w_nxt;
  always_comb begin
    w_nxt = r_fsm;
    unique case (r_fsm)
      IDLE, DONE: w_nxt = start ? (w_hit ? RND_A : EXPAND) : r_fsm;
      EXPAND:     w_nxt = r_rnd == 4'd9 ? RND_A : EXPAND;
      RND_A:      w_nxt = r_rnd == 4'd1 ? DONE : RND_B;
      RND_B:      w_nxt = RND_A;
      default:    w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (w_acc) begin
      r_state <= in_bus;
      r_key   <= w_hit ? w_rk10 : key;
    end else if (r_fsm == EXPAND)
      r_key <= w_ks;
    else if (r_fsm == RND_A) begin
      r_state <= w_isb;
      r_key   <= w_iks;
    end else if (r_fsm == RND_B)
      r_state <= w_imc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rnd   <= '0;
      out_bus <= '0;
    end else if (w_acc)
      r_rnd <= w_hit ? 4'd10 : 4'd0;
    else if (r_fsm == EXPAND)
      r_rnd <= r_rnd + 4'd1;
    else if (r_fsm == RND_A) begin
      r_rnd <= r_rnd - 4'd1;
      if (r_rnd == 4'd1)
        out_bus <= w_isb ^ w_iks;
    end
endmodule

// File: tb/tb_aes_128_inv.sv
// tb_aes_128_inv: randomized scoreboard bench for aes_128_inv against a table-driven AES-128 decryption model
module tb_aes_128_inv;
  logic clk = 1'b0;
  logic rst, start, ready, valid;
  logic [127:0] in_bus, key, out_bus;
  always #5 clk = ~clk;
  aes_128_inv dut (
    .clk(clk), .rst(rst), .start(start), .in_bus(in_bus), .key(key),
    .out_bus(out_bus), .ready(ready), .valid(valid)
  );
  typedef struct {logic [127:0] pt; int acc; int lat;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int checks = 0, failures = 0, cyc = 0;
  logic [127:0] last_pt;
  bit have_last = 0, pv = 0, tv = 0;
  logic [127:0] tag;
  logic [7:0] sb[256], isb[256];
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", n, act, req);
    end
  endtask
  task automatic check_i(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", n, act, req);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction
  // S-box by the classic generator walk over powers of 3 and 1/3, inverse box by table inversion
  task automatic build_sbox();
    logic [7:0] p = 1, qq = 1;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      qq ^= {qq[6:0], 1'b0};
      qq ^= {qq[5:0], 2'b0};
      qq ^= {qq[3:0], 4'b0};
      if (qq[7]) qq ^= 8'h09;
      sb[p] = qq ^ rl(qq, 1) ^ rl(qq, 2) ^ rl(qq, 3) ^ rl(qq, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask
  // Textbook InvCipher: full key expansion, then rounds 10..0 on a 16-byte column-major array
  function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] c);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] s[16], u[16], rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ w[40+i/4][31-8*(i%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int cl = 0; cl < 4; cl++)
        for (int rw = 0; rw < 4; rw++) u[4*cl+rw] = s[4*((cl-rw+4)%4)+rw];
      for (int i = 0; i < 16; i++) s[i] = isb[u[i]] ^ w[4*r+i/4][31-8*(i%4) -: 8];
      if (r > 0)
        for (int cl = 0; cl < 4; cl++) begin
          a0 = s[4*cl]; a1 = s[4*cl+1]; a2 = s[4*cl+2]; a3 = s[4*cl+3];
          s[4*cl]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
          s[4*cl+1] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
          s[4*cl+2] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
          s[4*cl+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
        end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p, input bit hold);
    int n = 0;
    int lat = 29;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL issue_wait: ready=%0b required 1", ready);
      return;
    end
    start = 1'b1;
    key = k;
    in_bus = c;
`ifdef AES_128_INV_KEY_CACHE_EN
    if (tv && k == tag) lat = 19;
    else begin
      tag = k;
      tv = 1;
    end
`endif
    q.push_back('{p, cyc + 1, lat});
    tick();
    if (!hold) start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    start = 1'b0;
    while (q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL done_wait: pending=%0d required 0", q.size());
      q.delete();
    end
  endtask
  task automatic garbage_pulse();
    start = 1'b1;
    key = {$urandom, $urandom, $urandom, $urandom};
    in_bus = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
  endtask
  always @(negedge clk)
    if (rst)
      pv = 0;
    else begin
      if (valid && !pv) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: out_bus=%h required no result", out_bus);
        end else begin
          e_m = q.pop_front();
          check("plaintext", out_bus, e_m.pt);
          check_i("latency", cyc - e_m.acc, e_m.lat);
          last_pt = e_m.pt;
          have_last = 1;
        end
      end else if (!valid) begin
        check("out_hold", out_bus, have_last ? last_pt : 128'h0);
        if (q.size() > 0 && cyc >= q[0].acc) check_i("ready_busy", int'(ready), 0);
      end
      pv = valid;
    end
  initial begin
    logic [127:0] k, c, pk;
    rst = 1'b1;
    start = 1'b0;
    in_bus = '0;
    key = '0;
    build_sbox();
    repeat (3) tick();
    check_i("reset_ready", int'(ready), 1);
    check_i("reset_valid", int'(valid), 0);
    check("reset_out", out_bus, 128'h0);
    rst = 1'b0;
    tick();
    issue(KC, CC, PC, 0);
    repeat (10) tick();
    check("rk10_after_expand", dut.r_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    wait_done();
    issue(KB, CB, PB, 0);
    wait_done();
    issue(KC, CC, PC, 0);
    repeat (4) tick();
    garbage_pulse();
    repeat (14) tick();
    garbage_pulse();
    wait_done();
    issue(KC, CC, PC, 1);
    issue(KB, CB, PB, 1);
    wait_done();
    issue(KC, CC, PC, 0);
    wait_done();
    issue(KC, CC, PC, 0);
    wait_done();
    issue(KB, CB, PB, 0);
    wait_done();
    pk = KB;
    for (int i = 0; i < 10; i++) begin
      k = (i % 3 == 2) ? pk : {$urandom, $urandom, $urandom, $urandom};
      c = {$urandom, $urandom, $urandom, $urandom};
      issue(k, c, ref_dec(k, c), i % 2 == 1);
      pk = k;
    end
    wait_done();
    issue(KB, CB, PB, 0);
    repeat (15) tick();
    rst = 1'b1;
    q.delete();
    have_last = 0;
    tv = 0;
    #1;
    check_i("abort_ready", int'(ready), 1);
    check_i("abort_valid", int'(valid), 0);
    check("abort_out", out_bus, 128'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    issue(KC, CC, PC, 0);
    wait_done();
    issue(KB, CB, PB, 0);
    wait_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
